// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-core front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snn_pkg;

  // Width of one sparse spike word presented to the synaptic core.
  localparam int SPARSE_W = 32;

  // Arbiter transaction phases: pick, hand word to core, await result, hand result out.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Advance an index by one, wrapping back to zero at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/syn_core_arb_rr_pick.sv
// Round-robin picker: first asserted request after 'last', wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            any,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IDW-1:0]  grant_idx
);
  import snn_pkg::*;

  // Walk NREQ positions starting just after 'last'; the first hit wins.
  // 'last' itself is visited last, so the previous winner has lowest priority.
  always_comb begin
    int idx;
    any          = 1'b0;
    grant_onehot = '0;
    grant_idx    = '0;
    idx          = int'(last);
    for (int k = 0; k < NREQ; k++) begin
      idx = wrap_inc(idx, NREQ);
      if (!any && req[idx]) begin
        any               = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/syn_core_arb.sv
// Round-robin arbiter sharing one synaptic core among NREQ spike-word requesters.
// Latency: accept at t, core_ipt_valid at t+1; rsp_valid the cycle after the core result handshake; min 4 cycles accept-to-accept.
// Backpressure: one transaction in flight; no new grant until the tagged response is taken downstream.
module syn_core_arb #(
  parameter int NREQ = 4,
  parameter int P    = 64,
  parameter int MWID = 12,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*32-1:0]  req_bits,
  output logic                core_ipt_valid,
  input  logic                core_ipt_ready,
  output logic [31:0]         core_sparse_bits,
  input  logic                core_opt_valid,
  output logic                core_opt_ready,
  input  logic [P*MWID-1:0]   core_opt_acc,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [P*MWID-1:0]   rsp_acc,
  output logic                busy
);
  import snn_pkg::*;

  arb_state_t          state;
  logic [IDW-1:0]      last;     // requester served by the most recently completed transaction
  logic [IDW-1:0]      gid_q;    // requester owning the in-flight transaction
  logic [SPARSE_W-1:0] word_q;   // spike word held for the core

  logic                pick_any;
  logic [NREQ-1:0]     pick_onehot;
  logic [IDW-1:0]      pick_idx;
  logic [SPARSE_W-1:0] pick_word;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req          (req_valid),
    .last         (last),
    .any          (pick_any),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx)
  );

  // Select the winner's word with a one-hot AND-OR mux.
  always_comb begin
    pick_word = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (pick_onehot[r]) begin
        pick_word = pick_word | req_bits[r*SPARSE_W +: SPARSE_W];
      end
    end
  end

  // The grant is only offered while idle and out of reset; everything else is registered.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && pick_any) begin
      req_ready = pick_onehot;
    end
  end

  assign core_sparse_bits = word_q;

  // Transaction FSM; handshake outputs are registered alongside the state.
  // The round-robin pointer moves only when a response completes, so an
  // abandoned (reset) transaction does not cost the requester its turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last           <= IDW'(NREQ - 1);
      gid_q          <= '0;
      word_q         <= '0;
      rsp_id         <= '0;
      rsp_acc        <= '0;
      core_ipt_valid <= 1'b0;
      core_opt_ready <= 1'b0;
      rsp_valid      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            word_q         <= pick_word;
            gid_q          <= pick_idx;
            state          <= ISSUE;
            core_ipt_valid <= 1'b1;
            busy           <= 1'b1;
          end
        end
        ISSUE: begin
          // Word stays on the bus until the core takes it.
          if (core_ipt_ready) begin
            state          <= WAIT;
            core_ipt_valid <= 1'b0;
            core_opt_ready <= 1'b1;
          end
        end
        WAIT: begin
          // Results are only accepted here; a core result outside WAIT is ignored.
          if (core_opt_valid) begin
            rsp_acc        <= core_opt_acc;
            rsp_id         <= gid_q;
            state          <= RESP;
            core_opt_ready <= 1'b0;
            rsp_valid      <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            last      <= gid_q;
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          core_ipt_valid <= 1'b0;
          core_opt_ready <= 1'b0;
          rsp_valid      <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

  // Protocol invariants: at most one grant, and held outputs do not move under backpressure.
  a_grant_onehot0: assert property (@(posedge clk) $onehot0(req_ready));

  a_ipt_hold: assert property (@(posedge clk) disable iff (rst)
    (core_ipt_valid && !core_ipt_ready) |=> (core_ipt_valid && $stable(core_sparse_bits)));

  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) && $stable(rsp_acc)));

endmodule

// File: tb/tb_syn_core_arb.sv
// Self-checking bench for syn_core_arb with a scripted core stub and a round-robin reference model.
// Latency: n/a.
// Backpressure: stub holds ipt_ready / rsp_ready low for programmable cycle counts.
module tb_syn_core_arb;

  localparam int NREQ = 4;
  localparam int P    = 64;
  localparam int MWID = 12;
  localparam int ACCW = P * MWID;
  localparam int IDW  = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_bits;
  logic              core_ipt_valid;
  logic              core_ipt_ready;
  logic [31:0]       core_sparse_bits;
  logic              core_opt_valid;
  logic              core_opt_ready;
  logic [ACCW-1:0]   core_opt_acc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [ACCW-1:0]   rsp_acc;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int last_m = NREQ - 1;          // reference: requester that completed most recently
  logic [31:0] words [NREQ];      // words currently offered by each requester

  always #5 clk = ~clk;

  syn_core_arb #(.NREQ(NREQ), .P(P), .MWID(MWID)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_bits         (req_bits),
    .core_ipt_valid   (core_ipt_valid),
    .core_ipt_ready   (core_ipt_ready),
    .core_sparse_bits (core_sparse_bits),
    .core_opt_valid   (core_opt_valid),
    .core_opt_ready   (core_opt_ready),
    .core_opt_acc     (core_opt_acc),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_id           (rsp_id),
    .rsp_acc          (rsp_acc),
    .busy             (busy)
  );

  function automatic logic [ACCW-1:0] rand_acc();
    logic [ACCW-1:0] a;
    for (int i = 0; i < ACCW / 32; i++) a[i*32 +: 32] = $urandom;
    return a;
  endfunction

  // Reference rule: scan from the requester after the last served one, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last_m + k) % NREQ]) return (last_m + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input bit fixed, input logic [31:0] w);
    for (int r = 0; r < NREQ; r++) begin
      words[r] = fixed ? w : $urandom;
      req_bits[r*32 +: 32] = words[r];
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0; core_ipt_ready = 1'b0; core_opt_valid = 1'b0;
    core_opt_acc = '0; rsp_ready = 1'b0; req_bits = '0;
    tick(); tick();
    rst = 1'b0;
    last_m = NREQ - 1;
  endtask

  // One full transaction from IDLE, checking every phase against the reference.
  task automatic do_txn(input logic [NREQ-1:0] vmask, input bit fixed, input logic [31:0] fw,
                        input int ipt_wait, input int opt_wait, input int rsp_wait,
                        input bit pulse, output int g);
    logic [ACCW-1:0] acc;
    logic [NREQ-1:0] exp_rdy;
    logic [31:0]     exp_word;
    acc = rand_acc();
    load_words(fixed, fw);
    req_valid = vmask;
    #1;
    g = model_pick(vmask);
    exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    checks++;
    if ({busy, req_ready} !== {1'b0, exp_rdy}) begin
      errors++;
      $display("FAIL grant: busy/req_ready=%b/%b required 0/%b", busy, req_ready, exp_rdy);
    end
    if (g < 0) begin
      req_valid = '0;
      return;
    end
    exp_word = words[g];
    tick();
    // Non-winners (and winner) change freely while the transaction is in flight.
    req_valid = vmask | NREQ'($urandom);
    load_words(1'b0, 32'h0);
    for (int c = 0; c <= ipt_wait; c++) begin
      core_ipt_ready = (c == ipt_wait);
      if (pulse) begin
        core_opt_valid = 1'b1;
        core_opt_acc   = rand_acc();
      end
      #1;
      checks++;
      if ({core_ipt_valid, core_opt_ready, rsp_valid, busy, req_ready, core_sparse_bits}
          !== {4'b1001, {NREQ{1'b0}}, exp_word}) begin
        errors++;
        $display("FAIL issue c=%0d: ipt_v/opt_r/rsp_v/busy=%b%b%b%b req_ready=%b word=%h required 1001 0000 %h",
                 c, core_ipt_valid, core_opt_ready, rsp_valid, busy, req_ready, core_sparse_bits, exp_word);
      end
      tick();
    end
    core_ipt_ready = 1'b0;
    core_opt_valid = 1'b0;
    for (int c = 0; c <= opt_wait; c++) begin
      core_opt_valid = (c == opt_wait);
      core_opt_acc   = (c == opt_wait) ? acc : rand_acc();
      #1;
      checks++;
      if ({core_ipt_valid, core_opt_ready, rsp_valid, busy, req_ready} !== {4'b0101, {NREQ{1'b0}}}) begin
        errors++;
        $display("FAIL wait c=%0d: ipt_v/opt_r/rsp_v/busy=%b%b%b%b req_ready=%b required 0101 0000",
                 c, core_ipt_valid, core_opt_ready, rsp_valid, busy, req_ready);
      end
      tick();
    end
    core_opt_valid = 1'b0;
    core_opt_acc   = rand_acc();
    for (int c = 0; c <= rsp_wait; c++) begin
      rsp_ready = (c == rsp_wait);
      #1;
      checks++;
      if ({core_ipt_valid, core_opt_ready, rsp_valid, busy, req_ready, rsp_id} !==
          {4'b0011, {NREQ{1'b0}}, IDW'(g)}) begin
        errors++;
        $display("FAIL resp c=%0d: ipt_v/opt_r/rsp_v/busy=%b%b%b%b req_ready=%b rsp_id=%0d required 0011 0000 %0d",
                 c, core_ipt_valid, core_opt_ready, rsp_valid, busy, req_ready, rsp_id, g);
      end
      checks++;
      if (rsp_acc !== acc) begin
        errors++;
        $display("FAIL rsp_acc c=%0d: low word %h required %h", c, rsp_acc[31:0], acc[31:0]);
      end
      tick();
    end
    rsp_ready = 1'b0;
    req_valid = '0;
    last_m = g;
    checks++;
    if ({busy, rsp_valid, core_opt_ready, core_ipt_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL done: busy/rsp_v/opt_r/ipt_v=%b%b%b%b required 0000",
               busy, rsp_valid, core_opt_ready, core_ipt_valid);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if ({busy, req_ready, core_ipt_valid, core_opt_ready, rsp_valid} !== {1'b0, {NREQ{1'b0}}, 3'b000}) begin
        errors++;
        $display("FAIL reset idle c=%0d: busy=%b req_ready=%b ipt_v=%b opt_r=%b rsp_v=%b required all 0",
                 c, busy, req_ready, core_ipt_valid, core_opt_ready, rsp_valid);
      end
      tick();
    end
    checks++;
    if ({rsp_id, core_sparse_bits} !== '0 || rsp_acc !== '0) begin
      errors++;
      $display("FAIL reset regs: rsp_id=%0d word=%h acc_lo=%h required 0", rsp_id, core_sparse_bits, rsp_acc[31:0]);
    end
    // While reset is held, valid requests must not be offered a grant.
    rst = 1'b1; req_valid = '1;
    #1;
    checks++;
    if ({req_ready, busy} !== '0) begin
      errors++;
      $display("FAIL reset grant: req_ready=%b busy=%b required 0", req_ready, busy);
    end
    tick();
    req_valid = '0;
    rst = 1'b0;
    last_m = NREQ - 1;
  endtask

  task automatic test_single();
    int g;
    do_txn(4'b0100, 1'b1, 32'h0000_0011, 0, 5, 0, 1'b0, g);
    checks++;
    if (g != 2) begin
      errors++;
      $display("FAIL single id: served %0d required 2", g);
    end
  endtask

  task automatic test_round_robin();
    int g;
    apply_reset();
    for (int i = 0; i < 2 * NREQ; i++) begin
      do_txn('1, 1'b0, 32'h0, 0, $urandom_range(0, 2), 0, 1'b0, g);
      checks++;
      if (g != i % NREQ) begin
        errors++;
        $display("FAIL rr order i=%0d: served %0d required %0d", i, g, i % NREQ);
      end
    end
  endtask

  task automatic test_backpressure();
    int g;
    do_txn(4'b1010, 1'b0, 32'h0, 3, 1, 4, 1'b0, g);
    do_txn(4'b1010, 1'b0, 32'h0, 3, 0, 4, 1'b0, g);
  endtask

  task automatic test_reset_mid_txn();
    int g;
    load_words(1'b0, 32'h0);
    req_valid = '1;
    tick();                       // accepted
    core_ipt_ready = 1'b1;
    tick();                       // core took the word, now waiting for the result
    core_ipt_ready = 1'b0;
    checks++;
    if ({core_opt_ready, busy} !== 2'b11) begin
      errors++;
      $display("FAIL mid wait: opt_r/busy=%b%b required 11", core_opt_ready, busy);
    end
    rst = 1'b1;
    core_opt_valid = 1'b1;
    core_opt_acc = rand_acc();
    tick();
    checks++;
    if ({busy, rsp_valid, core_opt_ready, core_ipt_valid, req_ready} !== '0 || rsp_acc !== '0) begin
      errors++;
      $display("FAIL mid reset: busy/rsp_v/opt_r/ipt_v=%b%b%b%b req_ready=%b acc_lo=%h required all 0",
               busy, rsp_valid, core_opt_ready, core_ipt_valid, req_ready, rsp_acc[31:0]);
    end
    rst = 1'b0;
    core_opt_valid = 1'b0;
    last_m = NREQ - 1;
    req_valid = 4'b0110;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL post reset grant: req_ready=%b required 0010", req_ready);
    end
    do_txn(4'b0110, 1'b0, 32'h0, 0, 0, 0, 1'b0, g);
  endtask

  task automatic test_opt_in_issue();
    int g;
    do_txn(4'b0011, 1'b0, 32'h0, 2, 2, 1, 1'b1, g);
    do_txn(4'b0011, 1'b0, 32'h0, 0, 0, 0, 1'b1, g);
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 24; i++) begin
      do_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'b0, 32'h0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), g);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_bits = '0;
    core_ipt_ready = 1'b0; core_opt_valid = 1'b0; core_opt_acc = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_txn();
    test_opt_in_issue();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
